// File: rtl/load_store_multi_arbiter.sv
// load_store_multi_arbiter
//   Arbitrates CH requestors onto the single load/store pipe request port and
//   routes each pipe response back to the channel that issued the request.
//   Grant is round-robin (iPRIO_MODE = 0) or fixed lowest-index priority
//   (iPRIO_MODE = 1). A grant stalled by iLDST_BUSY is locked until the pipe
//   accepts it. Accepted requests push their channel tag into an in-order FIFO
//   of DEPTH entries; each iLDST_VALID pops the head tag to steer the response.
//
// Ports
//   iCLOCK, inRESET          clock, asynchronous active-low reset
//   iPRIO_MODE               0 = round-robin, 1 = fixed priority
//   iREQ_*                   per-channel request bundle (CH lanes, packed)
//   oREQ_BUSY                per-channel stall; low only for the accepted lane
//   oLDST_*                  request to the pipe (granted lane's fields)
//   iLDST_BUSY               pipe stall
//   iLDST_VALID/MMU_FLAGS/DATA  pipe response
//   oRSP_VALID               one-hot response strobe (same cycle as iLDST_VALID)
//   oRSP_MMU_FLAGS/DATA      broadcast copy of the response payload
//   oOUTSTANDING             accepted-but-unanswered requests (0..DEPTH)
//   oERR_ORPHAN              sticky: response arrived with nothing outstanding

package load_store_multi_arbiter_pkg;
    typedef struct packed {
        logic [1:0]  order;
        logic [3:0]  mask;
        logic        rw;
        logic [13:0] asid;
        logic [1:0]  mmumod;
        logic [2:0]  mmups;
        logic [31:0] pdt;
        logic [31:0] addr;
        logic [31:0] data;
    } ldst_req_t;
endpackage

// Per-channel slice: gathers the lane's request fields (applying the forced
// full byte mask) and decodes this lane's busy and response strobe.
module load_store_multi_arbiter_lane
    import load_store_multi_arbiter_pkg::*;
#(
    parameter int CH_W     = 2,
    parameter int IDX      = 0,
    parameter bit FULLMASK = 1'b0
) (
    input  logic [1:0]      order,
    input  logic [3:0]      mask,
    input  logic            rw,
    input  logic [13:0]     asid,
    input  logic [1:0]      mmumod,
    input  logic [2:0]      mmups,
    input  logic [31:0]     pdt,
    input  logic [31:0]     addr,
    input  logic [31:0]     data,
    input  logic [CH_W-1:0] grant,
    input  logic            accept,
    input  logic            rsp_pop,
    input  logic [CH_W-1:0] rsp_ch,
    output ldst_req_t       req,
    output logic            busy,
    output logic            rsp_valid
);
    localparam logic [CH_W-1:0] ID = CH_W'(IDX);

    always_comb begin
        req        = '0;
        req.order  = order;
        req.mask   = FULLMASK ? 4'hf : mask;
        req.rw     = rw;
        req.asid   = asid;
        req.mmumod = mmumod;
        req.mmups  = mmups;
        req.pdt    = pdt;
        req.addr   = addr;
        req.data   = data;
    end

    assign busy      = !(accept && (grant == ID));
    assign rsp_valid = rsp_pop && (rsp_ch == ID);
endmodule

module load_store_multi_arbiter
    import load_store_multi_arbiter_pkg::*;
#(
    parameter int            CH          = 4,
    parameter int            DEPTH       = 4,
    parameter logic [CH-1:0] FULLMASK_CH = 'b0001,
    localparam int           CH_W        = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              iCLOCK,
    input  logic              inRESET,
    input  logic              iPRIO_MODE,
    input  logic [CH-1:0]     iREQ_VALID,
    output logic [CH-1:0]     oREQ_BUSY,
    input  logic [2*CH-1:0]   iREQ_ORDER,
    input  logic [4*CH-1:0]   iREQ_MASK,
    input  logic [CH-1:0]     iREQ_RW,
    input  logic [14*CH-1:0]  iREQ_ASID,
    input  logic [2*CH-1:0]   iREQ_MMUMOD,
    input  logic [3*CH-1:0]   iREQ_MMUPS,
    input  logic [32*CH-1:0]  iREQ_PDT,
    input  logic [32*CH-1:0]  iREQ_ADDR,
    input  logic [32*CH-1:0]  iREQ_DATA,
    output logic              oLDST_REQ,
    input  logic              iLDST_BUSY,
    output logic [1:0]        oLDST_ORDER,
    output logic [3:0]        oLDST_MASK,
    output logic              oLDST_RW,
    output logic [13:0]       oLDST_ASID,
    output logic [1:0]        oLDST_MMUMOD,
    output logic [2:0]        oLDST_MMUPS,
    output logic [31:0]       oLDST_PDT,
    output logic [31:0]       oLDST_ADDR,
    output logic [31:0]       oLDST_DATA,
    input  logic              iLDST_VALID,
    input  logic [11:0]       iLDST_MMU_FLAGS,
    input  logic [31:0]       iLDST_DATA,
    output logic [CH-1:0]     oRSP_VALID,
    output logic [11:0]       oRSP_MMU_FLAGS,
    output logic [31:0]       oRSP_DATA,
    output logic [CH_W+1:0]   oOUTSTANDING,
    output logic              oERR_ORPHAN
);
    localparam int              PTR_W   = $clog2(DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam int              OUT_W   = CH_W + 2;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(CH - 1);

    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  lock_ch;
    logic             lock;
    logic [CH_W-1:0]  grant;
    logic [CH_W-1:0]  scan_idx;
    logic             found;
    logic             full;
    logic             ldst_req;
    logic             accept;
    logic             rsp_pop;
    logic [CH_W-1:0]  rsp_ch;
    logic             orphan;

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CH_W-1:0]  tag_mem [DEPTH];

    ldst_req_t        lane_req [CH];
    ldst_req_t        sel;

    // Grant selection. A locked grant overrides everything, including a
    // mid-lock mode change or the locked lane dropping its valid. Otherwise
    // scan from the lowest index (fixed) or from rr_ptr with wrap (RR).
    always_comb begin
        grant    = lock_ch;
        found    = lock;
        scan_idx = '0;
        if (!lock) begin
            for (int k = 0; k < CH; k++) begin
                scan_idx = iPRIO_MODE ? CH_W'(k)
                                      : CH_W'((int'(rr_ptr) + k) % CH);
                if (!found && iREQ_VALID[scan_idx]) begin
                    found = 1'b1;
                    grant = scan_idx;
                end
            end
        end
    end

    // Full blocks issue even when a pop happens in the same cycle; the freed
    // slot becomes visible the following cycle through count.
    assign full     = (count == DEPTH_C);
    assign ldst_req = inRESET && found && !full;
    assign accept   = ldst_req && !iLDST_BUSY;
    assign rsp_pop  = inRESET && iLDST_VALID && (count != '0);
    assign rsp_ch   = tag_mem[rd_ptr];

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rr_ptr  <= '0;
            lock    <= 1'b0;
            lock_ch <= '0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            orphan  <= 1'b0;
        end else begin
            if (accept) begin
                lock <= 1'b0;
            end else if (ldst_req) begin
                lock    <= 1'b1;
                lock_ch <= grant;
            end

            if (accept && !iPRIO_MODE)
                rr_ptr <= (grant == LAST_CH) ? '0 : grant + CH_W'(1);

            if (accept)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (rsp_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);

            if (accept && !rsp_pop)
                count <= count + CNT_W'(1);
            else if (!accept && rsp_pop)
                count <= count - CNT_W'(1);

            if (iLDST_VALID && (count == '0))
                orphan <= 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read below count.
    always_ff @(posedge iCLOCK) begin
        if (accept)
            tag_mem[wr_ptr] <= grant;
    end

    for (genvar i = 0; i < CH; i++) begin : g_lane
        load_store_multi_arbiter_lane #(
            .CH_W     (CH_W),
            .IDX      (i),
            .FULLMASK (FULLMASK_CH[i])
        ) u_lane (
            .order     (iREQ_ORDER[i*2 +: 2]),
            .mask      (iREQ_MASK[i*4 +: 4]),
            .rw        (iREQ_RW[i]),
            .asid      (iREQ_ASID[i*14 +: 14]),
            .mmumod    (iREQ_MMUMOD[i*2 +: 2]),
            .mmups     (iREQ_MMUPS[i*3 +: 3]),
            .pdt       (iREQ_PDT[i*32 +: 32]),
            .addr      (iREQ_ADDR[i*32 +: 32]),
            .data      (iREQ_DATA[i*32 +: 32]),
            .grant     (grant),
            .accept    (accept),
            .rsp_pop   (rsp_pop),
            .rsp_ch    (rsp_ch),
            .req       (lane_req[i]),
            .busy      (oREQ_BUSY[i]),
            .rsp_valid (oRSP_VALID[i])
        );
    end

    assign sel            = lane_req[grant];
    assign oLDST_REQ      = ldst_req;
    assign oLDST_ORDER    = sel.order;
    assign oLDST_MASK     = sel.mask;
    assign oLDST_RW       = sel.rw;
    assign oLDST_ASID     = sel.asid;
    assign oLDST_MMUMOD   = sel.mmumod;
    assign oLDST_MMUPS    = sel.mmups;
    assign oLDST_PDT      = sel.pdt;
    assign oLDST_ADDR     = sel.addr;
    assign oLDST_DATA     = sel.data;

    assign oRSP_MMU_FLAGS = iLDST_MMU_FLAGS;
    assign oRSP_DATA      = iLDST_DATA;
    assign oOUTSTANDING   = OUT_W'(count);
    assign oERR_ORPHAN    = orphan;
endmodule

// File: doc/load_store_multi_arbiter.md
Name: load_store_multi_arbiter

Overview:
- N-channel successor to the two-source load/store pipe arbiter.
- Arbitrates CH requestors onto the single LDST pipe request port, using round-robin or fixed priority selected at runtime.
- Holds the grant while the pipe is busy.
- Tracks up to DEPTH outstanding accepted requests in an in-order tag FIFO so each LDST response returns only to the channel that issued it.
- Sits between execute, exception and other memory clients and the load/store pipe.

Parameters:
- CH, 4, number of requesting channels (2..8). CH_W = max(1, $clog2(CH)).
- DEPTH, 4, maximum outstanding accepted requests (power of two, ≥2).
- FULLMASK_CH, 'b0001, CH-bit vector; a set bit forces that channel's issued MASK to 4'hf.

Ports:
- iCLOCK  in  1  clock
- inRESET  in  1  asynchronous active-low reset
- iPRIO_MODE  in  1  0 = round-robin, 1 = fixed (lower index wins)
- iREQ_VALID  in  CH  per-channel request
- oREQ_BUSY  out  CH  per-channel stall; request not taken this cycle
- iREQ_ORDER  in  2*CH  per-channel access order
- iREQ_MASK  in  4*CH  per-channel byte mask
- iREQ_RW  in  CH  per-channel 1 = write
- iREQ_ASID  in  14*CH  per-channel ASID
- iREQ_MMUMOD  in  2*CH  per-channel MMU mode
- iREQ_MMUPS  in  3*CH  per-channel MMU page size
- iREQ_PDT  in  32*CH  per-channel page directory
- iREQ_ADDR  in  32*CH  per-channel address
- iREQ_DATA  in  32*CH  per-channel write data
- oLDST_REQ  out  1  request to pipe
- iLDST_BUSY  in  1  pipe stall
- oLDST_ORDER, oLDST_MASK, oLDST_RW, oLDST_ASID, oLDST_MMUMOD, oLDST_MMUPS, oLDST_PDT, oLDST_ADDR, oLDST_DATA  out  2/4/1/14/2/3/32/32/32  granted channel fields
- iLDST_VALID  in  1  pipe response valid
- iLDST_MMU_FLAGS  in  12  response MMU flags
- iLDST_DATA  in  32  response data
- oRSP_VALID  out  CH  one-hot response strobe
- oRSP_MMU_FLAGS  out  12  broadcast copy of iLDST_MMU_FLAGS
- oRSP_DATA  out  32  broadcast copy of iLDST_DATA
- oOUTSTANDING  out  CH_W+2  FIFO occupancy (0..DEPTH)
- oERR_ORPHAN  out  1  sticky; response received with FIFO empty

Behaviour:
- Reset (inRESET = 0, async):
  - rr_ptr = 0, lock = 0, lock_ch = 0, FIFO count/rd/wr pointers = 0, oERR_ORPHAN = 0.
  - While reset is asserted: oLDST_REQ = 0, oRSP_VALID = 0, oREQ_BUSY = all 1.
- Grant (combinational, zero latency):
  - If lock = 1, grant = lock_ch.
  - Else if iPRIO_MODE = 1, grant = lowest-index valid channel.
  - Else grant = first valid channel at or after rr_ptr, wrapping CH-1 → 0.
- Issue: oLDST_REQ = any_valid_or_lock AND (count < DEPTH). Output fields are a mux of the granted channel.
  - oLDST_MASK = 4'hf when FULLMASK_CH[grant] = 1, else iREQ_MASK[grant].
- Accept: accept = oLDST_REQ AND !iLDST_BUSY.
  - oREQ_BUSY[i] = !(accept AND grant == i). Non-granted valid channels see busy = 1.
- Lock: when oLDST_REQ = 1 and iLDST_BUSY = 1, the next-cycle lock = 1 with lock_ch = grant. Lock clears on accept.
  - Requestors hold valid and fields stable while busy.
  - Deasserting a locked channel's valid is a protocol violation. The block keeps lock until accept; no recovery is required.
- Round-robin: on accept in mode 0, rr_ptr = (grant+1) mod CH. In mode 1, rr_ptr is unchanged. Toggling the mode mid-lock does not break the lock.
- Full: count == DEPTH blocks issue (oLDST_REQ = 0, all busy) even if a pop occurs the same cycle. Issue resumes the cycle after the pop.
- Response routing:
  - iLDST_VALID with count > 0 pops the FIFO head ch. oRSP_VALID = one-hot(ch) in the same cycle (combinational).
  - Flags and data are always passed through.
- Simultaneous push and pop when not full: count is unchanged, both pointers advance, and the pop returns the older tag.
- Orphan: iLDST_VALID with count = 0 gives oRSP_VALID = 0 and sets oERR_ORPHAN until reset.
- Pointers wrap modulo DEPTH. oOUTSTANDING = count.

Test Plan:
- Reset, then CH0 and CH2 valid, mode 0, BUSY = 0 → cycle 1 grants CH0 (busy = 4'b1110); next grant goes to CH2; rr_ptr = 3.
- Mode 1, CH1 and CH3 continuously valid → CH1 is granted every cycle and CH3 is busy throughout. Switching to mode 0 alternates CH1 and CH3.
- CH2 granted with BUSY = 1 for 3 cycles while CH0 rises → grant stays CH2 with fields stable; accepted on the 4th cycle; then CH0 is granted.
- Accept CH3, CH1, CH3, CH0 (DEPTH = 4) → 5th request is blocked with oOUTSTANDING = 4. Four responses strobe oRSP_VALID 1000, 0010, 1000, 0001 in order.
- FULLMASK_CH = 0001 with CH0 mask 4'h3 → oLDST_MASK = 4'hf. CH1 mask 4'h3 → 4'h3.
- iLDST_VALID with FIFO empty → oRSP_VALID = 0, oERR_ORPHAN = 1 sticky. Asserting inRESET mid-stream with 2 outstanding → count = 0, flag = 0 immediately.
